// File: rtl/led_mode_ctrl.sv
// Four-LED sequencer with two debounced push-buttons selecting the pattern mode
// and the step speed. It owns the step timebase and drives the LEDs directly.
module led_mode_ctrl #(
  parameter int TICK_BASE    = 12_500_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       key_mode_n,
  input  logic       key_speed_n,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       step_pulse
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam int TW = $clog2(TICK_BASE);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_BASE - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

  localparam int KEY_MODE  = 0;
  localparam int KEY_SPEED = 1;

  // ---------------------------------------------------------------------------
  // Key path: 2-flop synchroniser and debounce counter, one lane per key.
  // ---------------------------------------------------------------------------
  logic [1:0]         raw_n;
  logic [1:0]         meta_q, meta_d;
  logic [1:0]         sync_q, sync_d;
  logic [1:0]         db_q, db_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         press;

  assign raw_n = {key_speed_n, key_mode_n};

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    meta_d   = raw_n;
    sync_d   = meta_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    press    = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync_q[k] == db_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DEB_LAST) begin
        db_cnt_d[k] = '0;
        db_d[k]     = sync_q[k];
        // The levels differ here, so a released debounced level means a press.
        press[k]    = db_q[k];
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timebase and pattern state
  // ---------------------------------------------------------------------------
  mode_e       mode_q, mode_d;
  logic [1:0]  mode_nxt;
  logic [1:0]  speed_q, speed_d;
  logic [3:0]  led_q, led_d;
  logic        dir_up_q, dir_up_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]  step_cnt_q, step_cnt_d;
  logic        step_pulse_q, step_pulse_d;
  logic [2:0]  div_last;
  logic        base_tick;
  logic        step;

  // Step divider is 8/4/2/1 base ticks for speed 0..3; this is div-1.
  always_comb begin
    case (speed_q)
      2'd0:    div_last = 3'd7;
      2'd1:    div_last = 3'd3;
      2'd2:    div_last = 3'd1;
      default: div_last = 3'd0;
    endcase
  end

  assign base_tick = run && (tick_cnt_q == TICK_LAST);
  assign step      = base_tick && (step_cnt_q == div_last);
  assign mode_nxt  = mode_q + 2'd1;

  always_comb begin
    mode_d       = mode_q;
    speed_d      = speed_q;
    led_d        = led_q;
    dir_up_d     = dir_up_q;
    tick_cnt_d   = tick_cnt_q;
    step_cnt_d   = step_cnt_q;
    step_pulse_d = 1'b0;

    if (run) begin
      tick_cnt_d = base_tick ? '0 : tick_cnt_q + 1'b1;
      if (base_tick) begin
        step_cnt_d = step ? 3'd0 : step_cnt_q + 3'd1;
      end
    end

    if (step) begin
      step_pulse_d = 1'b1;
      case (mode_q)
        MODE_LEFT:  led_d = {led_q[2:0], led_q[3]};
        MODE_RIGHT: led_d = {led_q[0], led_q[3:1]};
        MODE_BLINK: led_d = ~led_q;
        default: begin
          if (dir_up_q) begin
            if (led_q[3]) begin
              led_d    = 4'b0100;
              dir_up_d = 1'b0;
            end else begin
              led_d = {led_q[2:0], 1'b0};
            end
          end else if (led_q[0]) begin
            led_d    = 4'b0010;
            dir_up_d = 1'b1;
          end else begin
            led_d = {1'b0, led_q[3:1]};
          end
        end
      endcase
    end

    if (press[KEY_SPEED]) begin
      speed_d    = speed_q + 2'd1;
      step_cnt_d = 3'd0;
    end

    // A mode press overrides any coincident step and restarts the timebase.
    if (press[KEY_MODE]) begin
      mode_d       = mode_e'(mode_nxt);
      tick_cnt_d   = '0;
      step_cnt_d   = 3'd0;
      dir_up_d     = 1'b1;
      step_pulse_d = 1'b0;
      case (mode_e'(mode_nxt))
        MODE_LEFT:   led_d = 4'b0001;
        MODE_RIGHT:  led_d = 4'b1000;
        MODE_BLINK:  led_d = 4'b1111;
        default:     led_d = 4'b0001;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= '1;
      sync_q       <= '1;
      db_q         <= '1;
      db_cnt_q     <= '0;
      mode_q       <= MODE_LEFT;
      speed_q      <= 2'd1;
      led_q        <= 4'b0001;
      dir_up_q     <= 1'b1;
      tick_cnt_q   <= '0;
      step_cnt_q   <= 3'd0;
      step_pulse_q <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      led_q        <= led_d;
      dir_up_q     <= dir_up_d;
      tick_cnt_q   <= tick_cnt_d;
      step_cnt_q   <= step_cnt_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led        = led_q;
  assign mode       = mode_q;
  assign speed      = speed_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with a short timebase and debounce.
// Step patterns and their spacing go through a scoreboard queue.
module tb_led_mode_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       key_mode_n;
  logic       key_speed_n;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       step_pulse;

  led_mode_ctrl #(.TICK_BASE(4), .DEBOUNCE_CYC(8)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .run         (run),
    .key_mode_n  (key_mode_n),
    .key_speed_n (key_speed_n),
    .led         (led),
    .mode        (mode),
    .speed       (speed),
    .step_pulse  (step_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] led;
    int         gap;   // cycles since previous step / mode load / reset; 0 = not checked
  } exp_t;

  typedef struct {
    bit         m;
    bit         s;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] led;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ref_cyc = 0;
  logic [1:0] prev_mode = 2'd0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] l, input int g);
    exp_t e;
    e.led = l;
    e.gap = g;
    sb_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int left = budget;
    while (sb_q.size() != 0 && left > 0) begin
      @(negedge sys_clk);
      #1;
      left--;
    end
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    key_mode_n = 1'b1;
    key_speed_n = 1'b1;
    sb_q.delete();
    cycles(3);
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic press(input bit m, input bit s);
    key_mode_n  = ~m;
    key_speed_n = ~s;
    cycles(20);
    key_mode_n  = 1'b1;
    key_speed_n = 1'b1;
    cycles(25);
  endtask

  initial begin
    bit frozen_ok;

    tbl[0] = '{1'b1, 1'b0, 2'd1, 2'd1, 4'b1000};
    tbl[1] = '{1'b1, 1'b0, 2'd2, 2'd1, 4'b1111};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 2'd2, 4'b1111};
    tbl[3] = '{1'b1, 1'b0, 2'd3, 2'd2, 4'b0001};
    tbl[4] = '{1'b1, 1'b1, 2'd0, 2'd3, 4'b0001};
    tbl[5] = '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0001};
    tbl[6] = '{1'b1, 1'b0, 2'd1, 2'd0, 4'b1000};
    tbl[7] = '{1'b1, 1'b1, 2'd2, 2'd1, 4'b1111};

    rst_n = 1'b0;
    run = 1'b0;
    key_mode_n = 1'b1;
    key_speed_n = 1'b1;

    fork
      // Scoreboard monitor: pops one expectation per step pulse.
      forever begin
        exp_t e;
        @(negedge sys_clk);
        if (!rst_n) begin
          ref_cyc   = cyc;
          prev_mode = mode;
        end else begin
          if (mode != prev_mode) begin
            ref_cyc   = cyc;
            prev_mode = mode;
          end
          if (step_pulse) begin
            if (sb_q.size() == 0) begin
              check("unexpected_step", 1, 0);
            end else begin
              e = sb_q.pop_front();
              check("step_led", led, e.led);
              if (e.gap != 0) check("step_gap", cyc - ref_cyc, e.gap);
            end
            ref_cyc = cyc;
          end
        end
      end
    join_none

    // Reset state
    cycles(3);
    check("rst_led", led, 4'b0001);
    check("rst_mode", mode, 0);
    check("rst_speed", speed, 1);
    check("rst_step_pulse", step_pulse, 0);

    // Free-running LEFT rotate, one step per 16 cycles
    run = 1'b1;
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
    push_exp(4'b0010, 16);
    push_exp(4'b0100, 16);
    push_exp(4'b1000, 16);
    push_exp(4'b0001, 16);
    wait_empty(100, "left_steps_done");

    // Freeze with run=0 for 50 cycles; resume with the remaining count
    push_exp(4'b0010, 66);
    cycles(5);
    run = 1'b0;
    frozen_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (led != 4'b0001 || step_pulse) frozen_ok = 1'b0;
    end
    check("run0_frozen", frozen_ok, 1);
    run = 1'b1;
    wait_empty(40, "resume_step_done");
    run = 1'b0;

    // Short glitch is ignored
    key_mode_n = 1'b0;
    cycles(5);
    key_mode_n = 1'b1;
    cycles(30);
    check("glitch_mode", mode, 0);

    // Bouncing edges then a solid hold give exactly one increment
    for (int i = 0; i < 10; i++) begin
      key_mode_n = (i % 2 == 1);
      cycles(3);
    end
    key_mode_n = 1'b0;
    cycles(20);
    key_mode_n = 1'b1;
    cycles(30);
    check("bounce_key_mode", mode, 1);
    check("bounce_key_led", led, 4'b1000);

    press(1'b1, 1'b0);
    check("press2_mode", mode, 2);
    check("press2_led", led, 4'b1111);
    press(1'b1, 1'b0);
    check("press3_mode", mode, 3);
    check("press3_led", led, 4'b0001);

    // BOUNCE sequence
    run = 1'b1;
    push_exp(4'b0010, 0);
    push_exp(4'b0100, 16);
    push_exp(4'b1000, 16);
    push_exp(4'b0100, 16);
    push_exp(4'b0010, 16);
    push_exp(4'b0001, 16);
    push_exp(4'b0010, 16);
    wait_empty(200, "bounce_steps_done");
    run = 1'b0;

    // Table of key presses from reset, timebase frozen
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(tbl[i].m, tbl[i].s);
      check($sformatf("tbl%0d_mode", i), mode, tbl[i].mode);
      check($sformatf("tbl%0d_speed", i), speed, tbl[i].speed);
      check($sformatf("tbl%0d_led", i), led, tbl[i].led);
    end

    // Speed: two presses give 4-cycle steps, two more wrap to 16-cycle steps
    do_reset();
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("speed3", speed, 3);
    run = 1'b1;
    push_exp(4'b0010, 0);
    push_exp(4'b0100, 4);
    push_exp(4'b1000, 4);
    push_exp(4'b0001, 4);
    wait_empty(60, "speed3_steps_done");
    run = 1'b0;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("speed_wrap", speed, 1);
    run = 1'b1;
    push_exp(4'b0010, 0);
    push_exp(4'b0100, 16);
    push_exp(4'b1000, 16);
    wait_empty(80, "speed1_steps_done");
    run = 1'b0;

    // Reset mid-BLINK with a press part-way through debounce
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("blink_led", led, 4'b1111);
    run = 1'b1;
    push_exp(4'b0000, 0);
    wait_empty(40, "blink_step_done");
    run = 1'b0;
    key_mode_n = 1'b0;
    cycles(6);
    rst_n = 1'b0;
    #1;
    check("midrst_led", led, 4'b0001);
    check("midrst_mode", mode, 0);
    check("midrst_speed", speed, 1);
    check("midrst_step_pulse", step_pulse, 0);
    key_mode_n = 1'b1;
    cycles(3);
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
    cycles(30);
    check("aborted_press_mode", mode, 0);
    check("aborted_press_led", led, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Sequencer for the 4-LED bank. It replaces the fixed one-step-per-second rotate with a mode and speed controller driven by two push-buttons. Raw key inputs are synchronised and debounced internally. The block owns the step timebase and drives led directly from the board top level.

Parameters:
TICK_BASE, 12_500_000, sys_clk cycles per base tick (0.25 s at 50 MHz); legal range >= 2
DEBOUNCE_CYC, 1_000_000, cycles a synchronised key level must stay stable before it is accepted (20 ms); legal range >= 2

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  synchronous level enable; 0 = freeze pattern and timebase
key_mode_n  input  1  raw mode button, active-low, asynchronous to sys_clk
key_speed_n  input  1  raw speed button, active-low, asynchronous to sys_clk
led  output  4  LED drive, 1 = lit, registered
mode  output  2  current mode: 0 LEFT, 1 RIGHT, 2 BLINK, 3 BOUNCE, registered
speed  output  2  current speed level 0..3, registered
step_pulse  output  1  high for exactly the one cycle in which led first shows a new step pattern

Behaviour:
- Interface: one clock, sys_clk. Reset rst_n is asynchronous, active-low. Every flop, including the synchronisers, is cleared by rst_n.
- Reset values:
  - led = 4'b0001, mode = 0 (LEFT), speed = 1, step_pulse = 0.
  - All counters = 0.
  - Debounced key levels = 1 (released).
- Key path (per key):
  - 2-flop synchroniser feeds a debounce counter.
  - The counter clears whenever the synced level equals the debounced level.
  - Once the two differ for DEBOUNCE_CYC consecutive cycles, the debounced level takes the synced value.
  - A 1->0 transition of the debounced level produces a one-cycle press pulse. Release produces nothing.
  - Any pulse of fewer than DEBOUNCE_CYC-1 cycles is ignored.
- Timebase:
  - tick_cnt counts 0..TICK_BASE-1 and wraps; base tick fires on the terminal count.
  - step_cnt counts base ticks. A step fires on a base tick when step_cnt == div-1, then step_cnt wraps to 0.
  - div = 8, 4, 2, 1 for speed 0, 1, 2, 3. At reset, steps occur every 4*TICK_BASE cycles (1 s).
  - When run = 0, tick_cnt, step_cnt and led all hold, and step_pulse = 0. Key handling continues while run = 0.
- Mode press:
  - mode advances LEFT->RIGHT->BLINK->BOUNCE->LEFT.
  - On the same edge, led loads the new mode's initial pattern: LEFT 0001, RIGHT 1000, BLINK 1111, BOUNCE 0001 with direction up.
  - tick_cnt and step_cnt clear on that edge. A step coinciding with the press is discarded.
  - step_pulse stays 0 for a mode load.
- Speed press: speed increments mod 4 (3->0) and step_cnt clears. tick_cnt is unaffected.
- Mode and speed pressed on the same cycle: both updates apply on that edge.
- Step actions (led register updates on the step edge; step_pulse high the following cycle):
  - LEFT: led <= {led[2:0], led[3]}.
  - RIGHT: led <= {led[0], led[3:1]}.
  - BLINK: led <= ~led (1111 <-> 0000).
  - BOUNCE: one-hot position moves one place in the current direction. Direction reverses on reaching an end. Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
- led is always one of the defined patterns; there is no illegal state. Unused mode encodings do not exist.
- rst_n asserted mid-step or mid-debounce returns everything to reset values immediately. No press is remembered.

Test Plan:
- TICK_BASE=4, DEBOUNCE_CYC=8, run=1, no keys -> led steps 0001,0010,0100,1000,0001 every 16 cycles; step_pulse is one cycle wide each time; first step at cycle 16 after reset release.
- Hold key_mode_n low for 20 cycles, three times (waiting for release between presses) -> mode goes 1, 2, 3. led reloads to 1000, 1111, 0001 respectively. In BOUNCE, the next 7 steps give 0010,0100,1000,0100,0010,0001,0010.
- Speed press x2 from reset -> speed = 3 and steps every 4 cycles. Two more presses -> speed wraps to 1 and steps every 16 cycles.
- Glitch key_mode_n low for 5 cycles -> no mode change. Bouncing edges (toggling every 3 cycles for 30 cycles, then held low) -> exactly one mode increment.
- run=0 held for 50 cycles in LEFT mode -> led and step_pulse frozen. After run=1, the next step occurs after the remaining count, not a full period.
- Assert rst_n mid-BLINK with the debounce counter part-way -> led = 0001, mode = 0, speed = 1 immediately; the aborted press does not register after release.
